// File: rtl/d_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Sits between the CPU M stage and the external data SRAM port.
// Load hits complete in the issue cycle. Load misses and all stores stall
// the pipeline until the memory acknowledges.
// Memory handshake: mem_req is registered and is held together with
// mem_we/mem_w_en/mem_addr/mem_wdata until the cycle in which mem_ack=1.
// mem_req drops in the cycle after that. While mem_req=0, mem_ack is ignored.
module d_cache #(
   parameter int INDEX_BITS = 4,
   parameter int ADDR_W     = 16,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_re,
   input  logic [3:0]        cpu_w_en,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_w_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

   typedef enum logic [1:0] {IDLE, RD_MISS, WR} state_t;

   state_t state, state_next;

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES];

   logic [INDEX_BITS-1:0] cpu_idx, req_idx;
   logic [TAG_W-1:0]      cpu_tag, req_tag;
   logic                  cpu_hit, req_hit, is_store, is_load;
   logic                  unused_addr_bits;

   // Byte offset is irrelevant: the cache holds whole words.
   assign unused_addr_bits = ^cpu_addr[1:0];

   assign cpu_idx  = cpu_addr[INDEX_BITS+1:2];
   assign cpu_tag  = cpu_addr[ADDR_W-1:INDEX_BITS+2];
   assign req_idx  = mem_addr[INDEX_BITS+1:2];
   assign req_tag  = mem_addr[ADDR_W-1:INDEX_BITS+2];
   assign cpu_hit  = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
   assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign is_store = |cpu_w_en;
   assign is_load  = cpu_re && !is_store;

   // State register, line storage, latched memory request and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         valid_q    <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_w_en   <= 4'h0;
         mem_addr   <= '0;
         mem_wdata  <= 32'h0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (is_store) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_w_en  <= cpu_w_en;
                  mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                  mem_wdata <= cpu_wdata;
               end else if (is_load) begin
                  if (cpu_hit) begin
                     if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
                  end else begin
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_w_en <= 4'h0;
                     mem_addr <= {cpu_addr[ADDR_W-1:2], 2'b00};
                     if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
                  end
               end
            end
            RD_MISS: begin
               if (mem_ack) begin
                  mem_req          <= 1'b0;
                  valid_q[req_idx] <= 1'b1;
                  tag_q[req_idx]   <= req_tag;
                  data_q[req_idx]  <= mem_rdata;
               end
            end
            WR: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  // Write-through: update the line only if it is already resident.
                  if (req_hit) begin
                     for (int b = 0; b < 4; b++) begin
                        if (mem_w_en[b]) data_q[req_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state, stall and load-data selection.
   always_comb begin
      state_next = state;
      cpu_stall  = 1'b0;
      cpu_rdata  = 32'h0;
      case (state)
         IDLE: begin
            if (is_store) begin
               cpu_stall  = 1'b1;
               state_next = WR;
            end else if (is_load) begin
               if (cpu_hit) begin
                  cpu_rdata = data_q[cpu_idx];
               end else begin
                  cpu_stall  = 1'b1;
                  state_next = RD_MISS;
               end
            end
         end
         RD_MISS: begin
            cpu_stall = 1'b1;
            if (mem_ack) begin
               cpu_stall  = 1'b0;
               cpu_rdata  = mem_rdata;
               state_next = IDLE;
            end
         end
         WR: begin
            cpu_stall = 1'b1;
            if (mem_ack) begin
               cpu_stall  = 1'b0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (rst) begin
         cpu_stall  = 1'b0;
         cpu_rdata  = 32'h0;
         state_next = IDLE;
      end
   end

endmodule

// File: tb/tb_d_cache.sv
// Self-checking bench for d_cache: directed loads/stores with a small memory
// responder, a scoreboard of expected load data and memory requests, and a
// monitor that compares whenever the DUT completes a load or raises mem_req.
module tb_d_cache;

   logic        clk;
   logic        rst;
   logic        cpu_re;
   logic [3:0]  cpu_w_en;
   logic [15:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_w_en;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected load data, in completion order.
   logic [31:0] exp_q[$];
   // Expected memory requests: {we, w_en[3:0], addr[15:0], wdata[31:0]}.
   logic [52:0] exp_mem_q[$];
   logic        mem_req_prev = 1'b0;

   d_cache #(.INDEX_BITS(4), .ADDR_W(16), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .cpu_re(cpu_re), .cpu_w_en(cpu_w_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   // Clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: act=0x%08h exp=0x%08h", name, act, exp);
      end
   endtask

   // Monitor: load completions and new memory requests.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_req && !mem_req_prev) begin
            if (exp_mem_q.size() == 0) begin
               check("unexpected_mem_req", {16'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
               logic [52:0] e;
               e = exp_mem_q.pop_front();
               check("mem_we_addr", {15'h0, mem_we, mem_addr}, {15'h0, e[52], e[47:32]});
               if (e[52]) begin
                  check("mem_w_en", {28'h0, mem_w_en}, {28'h0, e[51:48]});
                  check("mem_wdata", mem_wdata, e[31:0]);
               end
            end
         end
         if (cpu_re && cpu_w_en == 4'h0 && !cpu_stall) begin
            if (exp_q.size() == 0) check("unexpected_load", cpu_rdata, 32'hFFFF_FFFF);
            else check("load_rdata", cpu_rdata, exp_q.pop_front());
         end
      end
      mem_req_prev <= mem_req;
   end

   // Runs an already-issued request to completion; returns stall cycle count.
   task automatic complete(input int ack_cyc, input logic [31:0] rdata, output int stalls);
      int t;
      stalls = 0;
      @(negedge clk);
      if (!cpu_stall) begin
         @(posedge clk); #1;
         return;
      end
      stalls = 1;
      @(posedge clk); #1;
      t = 0;
      while (!mem_req && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (!mem_req) begin
         check("mem_req_timeout", {31'h0, mem_req}, 32'h1);
         return;
      end
      for (int c = 1; c <= ack_cyc; c++) begin
         if (c == ack_cyc) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
         end
         @(negedge clk);
         if (cpu_stall) stalls++;
         @(posedge clk); #1;
         mem_ack = 1'b0;
      end
   endtask

   task automatic finish_req(input int exp_stalls, input int stalls);
      check("stall_cycles", stalls, exp_stalls);
      cpu_re   = 1'b0;
      cpu_w_en = 4'h0;
      @(negedge clk);
      check("mem_req_idle", {31'h0, mem_req}, 32'h0);
      @(posedge clk); #1;
   endtask

   task automatic do_load(input logic [15:0] a, input bit miss, input int ack_cyc,
                          input logic [31:0] refill, input logic [31:0] exp_data);
      int stalls;
      exp_q.push_back(exp_data);
      if (miss) exp_mem_q.push_back({1'b0, 4'h0, a, 32'h0});
      cpu_re   = 1'b1;
      cpu_w_en = 4'h0;
      cpu_addr = a;
      complete(ack_cyc, refill, stalls);
      finish_req(miss ? ack_cyc : 0, stalls);
   endtask

   task automatic do_store(input logic [15:0] a, input logic [3:0] we, input logic [31:0] d,
                           input int ack_cyc, input logic [15:0] exp_addr);
      int stalls;
      exp_mem_q.push_back({1'b1, we, exp_addr, d});
      cpu_re    = 1'b1;
      cpu_w_en  = we;
      cpu_addr  = a;
      cpu_wdata = d;
      complete(ack_cyc, 32'h0, stalls);
      finish_req(ack_cyc, stalls);
   endtask

   task automatic check_counts(input logic [15:0] h, input logic [15:0] m);
      @(negedge clk);
      check("hit_count", {16'h0, hit_count}, {16'h0, h});
      check("miss_count", {16'h0, miss_count}, {16'h0, m});
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; cpu_re = 1'b1; cpu_w_en = 4'h0; cpu_addr = 16'h0040;
      cpu_wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_stall", {31'h0, cpu_stall}, 32'h0);
      check("rst_rdata", cpu_rdata, 32'h0);
      check("rst_mem_req", {31'h0, mem_req}, 32'h0);
      check("rst_mem_we", {31'h0, mem_we}, 32'h0);
      check("rst_mem_w_en", {28'h0, mem_w_en}, 32'h0);
      check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_hits", {16'h0, hit_count}, 32'h0);
      check("rst_misses", {16'h0, miss_count}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; cpu_re = 1'b0;
      @(posedge clk); #1;

      // 1: cold miss, refill.
      do_load(16'h0040, 1'b1, 2, 32'hDEADBEEF, 32'hDEADBEEF);
      // 2: hit in the issue cycle.
      do_load(16'h0040, 1'b0, 0, 32'h0, 32'hDEADBEEF);
      check_counts(16'd1, 16'd1);
      // 3: conflict on index 0, then original address misses again.
      do_load(16'h0440, 1'b1, 1, 32'h12345678, 32'h12345678);
      do_load(16'h0040, 1'b1, 1, 32'h12345678, 32'h12345678);
      check_counts(16'd1, 16'd3);
      // 4: partial store merges into resident line.
      do_store(16'h0040, 4'b0011, 32'h0000AAAA, 3, 16'h0040);
      do_load(16'h0040, 1'b0, 0, 32'h0, 32'h1234AAAA);
      do_store(16'h0042, 4'b1000, 32'h55000000, 2, 16'h0040);
      do_load(16'h0043, 1'b0, 0, 32'h0, 32'h5534AAAA);
      check_counts(16'd3, 16'd3);
      // 5: store to an uncached line does not allocate.
      do_store(16'h0080, 4'b1111, 32'h0BADF00D, 1, 16'h0080);
      do_load(16'h0080, 1'b1, 2, 32'h0BADF00D, 32'h0BADF00D);
      check_counts(16'd3, 16'd4);

      // 6: reset in the middle of a refill, then a late ack.
      exp_mem_q.push_back({1'b0, 4'h0, 16'h0040, 32'h0});
      cpu_re = 1'b1; cpu_addr = 16'h0040;
      @(negedge clk);
      check("abort_stall", {31'h0, cpu_stall}, 32'h1);
      @(posedge clk); #1;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("abort_rst_stall", {31'h0, cpu_stall}, 32'h0);
      check("abort_rst_rdata", cpu_rdata, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; cpu_re = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      check("late_ack_mem_req", {31'h0, mem_req}, 32'h0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      check("late_ack_stall", {31'h0, cpu_stall}, 32'h0);
      @(posedge clk); #1;
      do_load(16'h0040, 1'b1, 2, 32'hCAFEF00D, 32'hCAFEF00D);
      check_counts(16'd0, 16'd1);

      check("exp_q_drained", exp_q.size(), 32'h0);
      check("exp_mem_q_drained", exp_mem_q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
